mrd_out_scaler: RTL and testbench

- Downstream stage of the mixed-radix DFT top. Consumes its 30-bit block-floating-point output stream and rounds/saturates each sample to OUT_W bits.
- Checks frame integrity (sop/eop against dftpts) and reports per-frame saturation and length errors alongside the narrowed stream.
- 2-stage pipeline with full valid/ready backpressure.

---
 rtl/mrd_out_scaler.sv | 185 ++++++++++++++++++
 tb/tb_mrd_out_scaler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrd_out_scaler.sv
// Output scaler for the mixed-radix DFT: rounds/saturates the block-floating-point
// stream to OUT_W bits and flags per-frame saturation and framing errors on eop.
module mrd_out_scaler #(
    parameter int IN_W  = 30,
    parameter int OUT_W = 16,
    parameter int SHIFT = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [IN_W-1:0]  in_real,
    input  logic [IN_W-1:0]  in_imag,
    input  logic [3:0]       in_exp,
    input  logic [11:0]      in_dftpts,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic [OUT_W-1:0] out_real,
    output logic [OUT_W-1:0] out_imag,
    output logic [3:0]       out_exp,
    output logic [11:0]      out_dftpts,
    output logic             out_sat,
    output logic             out_err
);
    localparam int YW = IN_W + 1;
    localparam logic signed [YW-1:0] HALF = YW'(1) << (SHIFT - 1);
    localparam logic signed [YW-1:0] SMAX = YW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [YW-1:0] SMIN = ~SMAX;

    typedef enum logic {IDLE, IN_FRAME} state_t;

    function automatic logic signed [YW-1:0] round_shift(input logic signed [IN_W-1:0] x);
        logic signed [YW-1:0] t;
        t = YW'(x) + HALF;
        return t >>> SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [YW-1:0] y);
        if (y > SMAX)
            return {1'b1, SMAX[OUT_W-1:0]};
        else if (y < SMIN)
            return {1'b1, SMIN[OUT_W-1:0]};
        else
            return {1'b0, y[OUT_W-1:0]};
    endfunction

    state_t      state, state_nx;
    logic        en, xfer, fwd, err_beat, pend, pend_nx;
    logic [11:0] cnt, cnt_nx, cnt_beat, dft_lat, dft_nx, frame_dft;

    logic                 vld_p1, sop_p1, eop_p1, err_p1;
    logic signed [YW-1:0] yre_p1, yim_p1;
    logic [3:0]           exp_p1;
    logic [11:0]          dft_p1;

    logic                 vld_p2, sop_p2, eop_p2, sat_p2, err_p2, sat_run;
    logic [OUT_W-1:0]     re_p2, im_p2;
    logic [3:0]           exp_p2;
    logic [11:0]          dft_p2;

    logic [OUT_W:0]       sre, sim;
    logic                 frame_sat;

    assign en       = !vld_p2 || out_ready;
    assign in_ready = en && !rst;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dft_lat <= '0;
            pend    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            dft_lat <= dft_nx;
            pend    <= pend_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        dft_nx    = dft_lat;
        pend_nx   = pend;
        fwd       = 1'b0;
        err_beat  = 1'b0;
        frame_dft = in_sop ? in_dftpts : dft_lat;
        cnt_beat  = in_sop ? 12'd1 : ((cnt == 12'hFFF) ? cnt : cnt + 12'd1);
        if (xfer) begin
            if (state == IDLE && !in_sop) begin
                pend_nx = 1'b1;
            end else begin
                fwd      = 1'b1;
                // A sop arriving inside a frame aborts the frame in progress.
                err_beat = (state == IN_FRAME) && in_sop;
                cnt_nx   = cnt_beat;
                dft_nx   = frame_dft;
                if (in_eop) begin
                    err_beat = err_beat || pend || (cnt_beat != frame_dft);
                    pend_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    state_nx = IN_FRAME;
                end
            end
        end
    end

    // Stage 1: round and shift, attach framing status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            sop_p1 <= 1'b0;
            eop_p1 <= 1'b0;
            err_p1 <= 1'b0;
            yre_p1 <= '0;
            yim_p1 <= '0;
            exp_p1 <= '0;
            dft_p1 <= '0;
        end else if (en) begin
            vld_p1 <= fwd;
            if (fwd) begin
                sop_p1 <= in_sop;
                eop_p1 <= in_eop;
                err_p1 <= err_beat;
                yre_p1 <= round_shift($signed(in_real));
                yim_p1 <= round_shift($signed(in_imag));
                exp_p1 <= in_exp;
                dft_p1 <= in_dftpts;
            end
        end
    end

    assign sre       = saturate(yre_p1);
    assign sim       = saturate(yim_p1);
    assign frame_sat = (sop_p1 ? 1'b0 : sat_run) | sre[OUT_W] | sim[OUT_W];

    // Stage 2: saturate, accumulate frame saturation, hold output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            sop_p2  <= 1'b0;
            eop_p2  <= 1'b0;
            sat_p2  <= 1'b0;
            err_p2  <= 1'b0;
            sat_run <= 1'b0;
            re_p2   <= '0;
            im_p2   <= '0;
            exp_p2  <= '0;
            dft_p2  <= '0;
        end else if (en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sop_p2  <= sop_p1;
                eop_p2  <= eop_p1;
                err_p2  <= err_p1;
                sat_p2  <= eop_p1 && frame_sat;
                sat_run <= frame_sat;
                re_p2   <= sre[OUT_W-1:0];
                im_p2   <= sim[OUT_W-1:0];
                if (sop_p1) begin
                    exp_p2 <= exp_p1;
                    dft_p2 <= dft_p1;
                end
            end
        end
    end

    assign out_valid  = vld_p2;
    assign out_sop    = sop_p2;
    assign out_eop    = eop_p2;
    assign out_sat    = sat_p2;
    assign out_err    = err_p2;
    assign out_real   = re_p2;
    assign out_imag   = im_p2;
    assign out_exp    = exp_p2;
    assign out_dftpts = dft_p2;
endmodule

// File: tb/tb_mrd_out_scaler.sv
// Scoreboard bench for mrd_out_scaler: a frame-level reference model predicts every
// forwarded beat; a monitor pops and compares whenever the DUT hands one over.
module tb_mrd_out_scaler;
    localparam int IN_W  = 30;
    localparam int OUT_W = 16;
    localparam int SHIFT = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_sop, in_eop;
    logic [IN_W-1:0]  in_real, in_imag;
    logic [3:0]       in_exp;
    logic [11:0]      in_dftpts;
    logic             out_valid, out_ready, out_sop, out_eop, out_sat, out_err;
    logic [OUT_W-1:0] out_real, out_imag;
    logic [3:0]       out_exp;
    logic [11:0]      out_dftpts;

    mrd_out_scaler #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
        .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp), .in_dftpts(in_dftpts),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_real(out_real), .out_imag(out_imag), .out_exp(out_exp), .out_dftpts(out_dftpts),
        .out_sat(out_sat), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] re, im;
        logic             sop, eop, sat, err;
        logic [3:0]       ex;
        logic [11:0]      dft;
        bit               lat;
        int               acc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    bit          rdy_rand = 1'b0, lat_next = 1'b0;
    bit          m_in_frame = 1'b0, m_pend = 1'b0, m_fsat = 1'b0;
    int          m_n = 0;
    logic [3:0]  m_ex = '0;
    logic [11:0] m_dft = '0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint pack(input logic sop, eop, sat, err, input logic [3:0] ex,
                                    input logic [11:0] dft, input logic [OUT_W-1:0] re, im);
        return longint'({sop, eop, sat, err, ex, dft, re, im});
    endfunction

    // Round-half-up division by 2^SHIFT followed by clamping to OUT_W bits.
    function automatic longint scale(input longint x, output bit clipped);
        longint n, d, q, hi, lo;
        d  = longint'(1) << SHIFT;
        n  = x + d / 2;
        q  = n / d;
        if (n < 0 && (n % d) != 0) q = q - 1;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -hi - 1;
        clipped = (q > hi) || (q < lo);
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    function automatic void model_accept(input bit sop, eop, input longint re, im,
                                         input logic [3:0] ex, input logic [11:0] dft);
        exp_t   e;
        bit     abort, s1, s2;
        longint r, i;
        if (!m_in_frame && !sop) begin
            m_pend = 1'b1;
            return;
        end
        abort = m_in_frame && sop;
        if (sop) begin
            m_in_frame = 1'b1; m_ex = ex; m_dft = dft; m_n = 1; m_fsat = 1'b0;
        end else if (m_n < 4095) begin
            m_n++;
        end
        r = scale(re, s1);
        i = scale(im, s2);
        m_fsat = m_fsat | s1 | s2;
        e.re = r[OUT_W-1:0]; e.im = i[OUT_W-1:0];
        e.sop = sop; e.eop = eop; e.ex = m_ex; e.dft = m_dft;
        e.err = abort; e.sat = 1'b0;
        e.lat = lat_next; lat_next = 1'b0; e.acc = cyc;
        if (eop) begin
            if (m_pend || m_n != int'(m_dft)) e.err = 1'b1;
            e.sat = m_fsat;
            m_pend = 1'b0;
            m_in_frame = 1'b0;
        end
        sb.push_back(e);
    endfunction

    task automatic send(input bit sop, eop, input longint re, im,
                        input logic [3:0] ex, input logic [11:0] dft);
        int w = 0;
        in_valid = 1'b1; in_sop = sop; in_eop = eop;
        in_real = re[IN_W-1:0]; in_imag = im[IN_W-1:0];
        in_exp = ex; in_dftpts = dft;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(sop, eop, re, im, ex, dft);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            w++;
            if (w > 2000) begin
                check("accept_timeout", w, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic longint rnd();
        logic [IN_W-1:0] b;
        b = IN_W'($urandom);
        case ($urandom_range(0, 3))
            0: return longint'($urandom_range(0, 80000)) - 40000;
            1: return longint'($signed(b));
            2: return ($urandom_range(0, 1) ? (longint'(1) << (IN_W - 1)) - 1 - longint'($urandom_range(0, 20000))
                                            : -(longint'(1) << (IN_W - 1)) + longint'($urandom_range(0, 20000)));
            default: return (longint'($urandom_range(0, 200)) - 100) * (longint'(1) << SHIFT)
                            + (longint'(1) << (SHIFT - 1)) - longint'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic frame(input int nbeats, input bit with_eop, input logic [11:0] dft, input bit gaps);
        logic [3:0] ex;
        ex = 4'($urandom);
        for (int k = 0; k < nbeats; k++) begin
            send(k == 0, with_eop && (k == nbeats - 1), rnd(), rnd(), ex, dft);
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
    endtask

    task automatic drain();
        int w = 0;
        rdy_rand = 1'b0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_fields"}, pack(out_sop, out_eop, out_sat, out_err, out_exp, out_dftpts,
                                     out_real, out_imag), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk); #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: handshake invariant, stall stability and scoreboard comparison.
    initial begin
        bit     stall_prev = 1'b0;
        longint prev_pkt = 0, cur;
        exp_t   e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                continue;
            end
            cur = pack(out_sop, out_eop, out_sat, out_err, out_exp, out_dftpts, out_real, out_imag);
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (stall_prev && out_valid) check("stall_stable", cur, prev_pkt);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", cur, -1);
                end else begin
                    e = sb.pop_front();
                    check("beat", cur, pack(e.sop, e.eop, e.sat, e.err, e.ex, e.dft, e.re, e.im));
                    if (e.lat) check("latency", cyc - e.acc, 2);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_pkt   = cur;
        end
    end

    initial begin
        longint t1[4] = '{1638400, 8192, -8192, 24576};
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_real = '0; in_imag = '0; in_exp = '0; in_dftpts = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Directed four-point frame with known rounding results.
        for (int k = 0; k < 4; k++) begin
            lat_next = (k == 0);
            send(k == 0, k == 3, t1[k], 0, 4'd3, 12'd4);
        end
        drain();

        // Saturation at both extremes inside a 12-sample frame.
        for (int k = 0; k < 12; k++)
            send(k == 0, k == 11,
                 (k == 3) ? (longint'(1) << 29) - 1 : (k == 7) ? -(longint'(1) << 29)
                                                           : longint'($urandom_range(0, 200000)) - 100000,
                 longint'($urandom_range(0, 200000)) - 100000, 4'd5, 12'd12);
        drain();

        // Short frame, then a correct one.
        frame(10, 1'b1, 12'd12, 1'b0);
        frame(12, 1'b1, 12'd12, 1'b0);
        drain();

        // Random backpressure with continuous input.
        rdy_rand = 1'b1;
        frame(12, 1'b1, 12'd12, 1'b0);
        drain();

        // Stray beats from IDLE, then two good frames.
        send(1'b0, 1'b0, rnd(), rnd(), 4'd1, 12'd12);
        send(1'b0, 1'b0, rnd(), rnd(), 4'd1, 12'd12);
        frame(12, 1'b1, 12'd12, 1'b0);
        frame(12, 1'b1, 12'd12, 1'b0);
        drain();

        // Reset in the middle of a frame.
        rdy_rand = 1'b1;
        frame(5, 1'b0, 12'd12, 1'b0);
        rst = 1'b1;
        sb.delete();
        m_in_frame = 1'b0; m_pend = 1'b0;
        reset_checks("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        frame(12, 1'b1, 12'd12, 1'b0);
        drain();

        // Randomized frames: lengths, mismatched dftpts, aborts, gaps, stalls.
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(1, 16);
            rdy_rand = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) frame($urandom_range(1, 4), 1'b0, 12'(len), 1'b1);
            frame(len, 1'b1, ($urandom_range(0, 3) == 0) ? 12'(len + 1) : 12'(len), 1'b1);
            if ($urandom_range(0, 7) == 0) send(1'b0, 1'b0, rnd(), rnd(), 4'd0, 12'd1);
        end
        drain();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
